median_ctrl: RTL

//  Frame sequencer for the median filter datapath. On a start pulse it walks one frame:
//  - drives the three row-window read addresses (raddr_a/b/c) into the input LUT memories;
//  - tracks the datapath latency with a valid delay line;
//  - issues write enables and addresses (waddr) to the output memory;
//  - signals done.

---
 rtl/median_ctrl_pkg.sv | 25 ++
 rtl/median_valid_pipe.sv | 40 ++++
 rtl/median_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/median_ctrl_pkg.sv
// Shared types and elaboration helpers for the median filter frame sequencer.
// Pure declarations: no latency, no flow control.
package median_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Frame geometry must fit the address buses; there is no runtime wrap handling.
  function automatic bit params_ok(input int lut_aw, input int mem_aw, input int row_words,
                                   input int img_rows, input int pipe_lat);
    return (row_words >= 1) && (img_rows >= 3) && (pipe_lat >= 1) &&
           (img_rows * row_words <= (1 << lut_aw)) &&
           ((img_rows - 2) * row_words <= (1 << mem_aw));
  endfunction

endpackage

// File: rtl/median_valid_pipe.sv
// Valid delay line: out is in delayed by DEPTH cycles; any flags a valid still upstream of out.
// Latency DEPTH cycles; no backpressure, clr empties every stage on the next edge.
module median_valid_pipe #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in,
  output logic out,
  output logic any
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // any excludes the output stage so a frame can retire in the same cycle as its last write.
  if (DEPTH == 1) begin : g_one
    always_comb begin
      sr_d = clr ? 1'b0 : in;
      any  = in;
    end
  end else begin : g_many
    always_comb begin
      sr_d = clr ? '0 : {sr_q[DEPTH-2:0], in};
      any  = in | (|sr_q[DEPTH-2:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign out = sr_q[DEPTH-1];

endmodule

// File: rtl/median_ctrl.sv
// Frame sequencer: walks the three-row read window, tracks datapath latency, drives output writes.
// First read one cycle after start, writes PIPE_LATENCY cycles after reads; no backpressure.
module median_ctrl
  import median_ctrl_pkg::*;
#(
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int ROW_WORDS      = 4,
  parameter int IMG_ROWS       = 5,
  parameter int PIPE_LATENCY   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [LUT_ADDR_WIDTH-1:0] raddr_a,
  output logic [LUT_ADDR_WIDTH-1:0] raddr_b,
  output logic [LUT_ADDR_WIDTH-1:0] raddr_c,
  output logic                      we,
  output logic [MEM_ADDR_WIDTH-1:0] waddr
);

  localparam int LW    = LUT_ADDR_WIDTH;
  localparam int MW    = MEM_ADDR_WIDTH;
  localparam int COL_W = cnt_width(ROW_WORDS);
  localparam int ROW_W = cnt_width(IMG_ROWS);

  localparam logic [LW-1:0]    ROW_STEP  = LW'(ROW_WORDS);
  localparam logic [LW-1:0]    ROW_STEP2 = LW'(2 * ROW_WORDS);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(ROW_WORDS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_ROWS - 3);

  if (!params_ok(LUT_ADDR_WIDTH, MEM_ADDR_WIDTH, ROW_WORDS, IMG_ROWS, PIPE_LATENCY)) begin : g_param_err
    $error("median_ctrl: frame geometry does not fit the address widths or latency/rows out of range");
  end

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [LW-1:0]    base_a_q, base_a_d;
  logic [LW-1:0]    base_b_q, base_b_d;
  logic [LW-1:0]    base_c_q, base_c_d;
  logic [LW-1:0]    raddr_a_q, raddr_a_d;
  logic [LW-1:0]    raddr_b_q, raddr_b_d;
  logic [LW-1:0]    raddr_c_q, raddr_c_d;
  logic [MW-1:0]    waddr_q, waddr_d;

  logic pipe_clr;
  logic pipe_out;
  logic pipe_any;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    base_c_d  = base_c_q;
    raddr_a_d = raddr_a_q;
    raddr_b_d = raddr_b_q;
    raddr_c_d = raddr_c_q;
    waddr_d   = waddr_q;
    pipe_clr  = 1'b0;

    if (pipe_out) begin
      waddr_d = waddr_q + MW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_RUN;
          col_d    = '0;
          row_d    = '0;
          base_a_d = '0;
          base_b_d = ROW_STEP;
          base_c_d = ROW_STEP2;
          waddr_d  = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d  = ST_IDLE;
          pipe_clr = 1'b1;
          waddr_d  = '0;
        end else if (row_q == ROW_LAST && col_q == COL_LAST) begin
          state_d = ST_FLUSH;
        end else if (col_q == COL_LAST) begin
          // Row wrap: slide the whole three-row window down by one row.
          col_d    = '0;
          row_d    = row_q + ROW_W'(1);
          base_a_d = base_a_q + ROW_STEP;
          base_b_d = base_b_q + ROW_STEP;
          base_c_d = base_c_q + ROW_STEP;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          state_d  = ST_IDLE;
          pipe_clr = 1'b1;
          waddr_d  = '0;
        end else if (!pipe_any) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_RUN) begin
      raddr_a_d = base_a_d + LW'(col_d);
      raddr_b_d = base_b_d + LW'(col_d);
      raddr_c_d = base_c_d + LW'(col_d);
    end

    rd_en_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    done_d  = (state_q == ST_FLUSH) && (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      base_c_q  <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      raddr_c_q <= '0;
      waddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_a_q  <= base_a_d;
      base_b_q  <= base_b_d;
      base_c_q  <= base_c_d;
      raddr_a_q <= raddr_a_d;
      raddr_b_q <= raddr_b_d;
      raddr_c_q <= raddr_c_d;
      waddr_q   <= waddr_d;
    end
  end

  median_valid_pipe #(
    .DEPTH(PIPE_LATENCY)
  ) u_valid_pipe (
    .clk(clk),
    .rst(rst),
    .clr(pipe_clr),
    .in (rd_en_q),
    .out(pipe_out),
    .any(pipe_any)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign raddr_a = raddr_a_q;
  assign raddr_b = raddr_b_q;
  assign raddr_c = raddr_c_q;
  assign we      = pipe_out;
  assign waddr   = waddr_q;

endmodule
